// File: rtl/iic_master.sv
// Single-master I2C controller: one register-oriented read or write per command.
// Each bus step is four quarters of CLK_DIV clocks. SCL is push-pull; SDA is open-drain.
module iic_master #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_dev,
    input  logic [7:0]  cmd_reg,
    input  logic [1:0]  cmd_len,
    input  logic [31:0] cmd_wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        ack_err,
    output logic        busy,
    output logic        scl,
    inout  wire         sda
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, DEVW, REG, WDATA, RSTART, DEVR, RDATA, SACK, MACK, STOP
    } state_t;

    state_t        state_q, state_d, ret_q, ret_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic          rw_q, rw_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic [1:0]    len_q, len_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ack_err_q, ack_err_d;
    logic          done_q, done_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          tick;
    logic [7:0]    tx_byte;

    // Returns {scl, sda_oe} for a given step and quarter.
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                             input logic tx_bit, input logic mack_low);
        logic [1:0] r;
        r = 2'b10;
        case (st)
            START:  r = (q == 2'd0) ? 2'b10 : (q == 2'd1) ? 2'b11 : 2'b01;
            RSTART: begin
                case (q)
                    2'd0:    r = 2'b00;
                    2'd1:    r = 2'b10;
                    2'd2:    r = 2'b11;
                    default: r = 2'b01;
                endcase
            end
            STOP:   r = (q == 2'd0) ? 2'b01 : (q == 2'd1) ? 2'b11 : 2'b10;
            DEVW, REG, WDATA, DEVR: r = {q[1], ~tx_bit};
            RDATA, SACK:            r = {q[1], 1'b0};
            MACK:                   r = {q[1], mack_low};
            default:                r = 2'b10;
        endcase
        return r;
    endfunction

    assign tick = (state_q != IDLE) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        tx_byte   = '0;

        if (state_q == IDLE) begin
            cnt_d = '0;
            if (cmd_valid) begin
                rw_d      = cmd_rw;
                dev_d     = cmd_dev;
                reg_d     = cmd_reg;
                len_d     = cmd_len;
                wdata_d   = cmd_wdata;
                rdata_d   = '0;
                ack_err_d = 1'b0;
                state_d   = START;
                qtr_d     = '0;
                bit_d     = 3'd7;
                byte_d    = '0;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                qtr_d = qtr_q + 2'd1;
                if (state_q == RDATA && qtr_q == 2'd3)
                    rdata_d[{byte_q, bit_q}] = sda;
                if (qtr_q == 2'd3) begin
                    case (state_q)
                        START:  state_d = DEVW;
                        RSTART: state_d = DEVR;
                        DEVW, REG, WDATA, DEVR, RDATA: begin
                            if (bit_q == 3'd0) begin
                                bit_d   = 3'd7;
                                state_d = (state_q == RDATA) ? MACK : SACK;
                                // The byte index advances here so SACK only needs a return state.
                                case (state_q)
                                    DEVW: ret_d = REG;
                                    REG:  ret_d = rw_q ? RSTART : WDATA;
                                    DEVR: ret_d = RDATA;
                                    WDATA: begin
                                        if (byte_q == len_q) begin
                                            ret_d = STOP;
                                        end else begin
                                            ret_d  = WDATA;
                                            byte_d = byte_q + 2'd1;
                                        end
                                    end
                                    default: ret_d = ret_q;
                                endcase
                            end else begin
                                bit_d = bit_q - 3'd1;
                            end
                        end
                        SACK: begin
                            if (sda) begin
                                ack_err_d = 1'b1;
                                state_d   = STOP;
                            end else begin
                                state_d = ret_q;
                            end
                        end
                        MACK: begin
                            if (byte_q == len_q) begin
                                state_d = STOP;
                            end else begin
                                byte_d  = byte_q + 2'd1;
                                state_d = RDATA;
                            end
                        end
                        STOP: begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end

        // Bus pins are registered from the next step so they change together with the state.
        case (state_d)
            DEVW:    tx_byte = {dev_d, 1'b0};
            REG:     tx_byte = reg_d;
            WDATA:   tx_byte = wdata_d[{byte_d, 3'b000} +: 8];
            DEVR:    tx_byte = {dev_d, 1'b1};
            default: tx_byte = '0;
        endcase
        {scl_d, sda_oe_d} = bus_drive(state_d, qtr_d, tx_byte[bit_d], byte_d != len_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ret_q     <= IDLE;
            cnt_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            rw_q      <= 1'b0;
            dev_q     <= '0;
            reg_q     <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign ack_err   = ack_err_q;
    assign scl       = scl_q;
    assign sda       = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_iic_master.sv
// Directed bench for iic_master with a behavioural register slave (dev 0x01:
// reg 0x00 8-bit, reg 0x01 32-bit) on a pulled-up SDA line.
module tb_iic_master;

    localparam int unsigned CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [6:0]  cmd_dev = '0;
    logic [7:0]  cmd_reg = '0;
    logic [1:0]  cmd_len = '0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] rdata;
    logic        done, ack_err, busy, scl;
    wire         sda_bus;

    pullup (sda_bus);

    iic_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
        .cmd_wdata(cmd_wdata), .rdata(rdata), .done(done), .ack_err(ack_err),
        .busy(busy), .scl(scl), .sda(sda_bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SCL rising-edge timestamps
    int unsigned rise_n = 0;
    int unsigned rise_cyc [1024];
    logic        mon_scl = 1'b1;
    always @(negedge clk) begin
        mon_scl <= scl;
        if (scl && !mon_scl && rise_n < 1024) begin
            rise_cyc[rise_n] <= cyc;
            rise_n <= rise_n + 1;
        end
    end

    // Slave model
    typedef enum logic [2:0] {S_IDLE, S_RX, S_ACK, S_TX, S_MACK} slv_t;
    slv_t        s_ph = S_IDLE;
    logic        s_prev_scl = 1'b1, s_prev_sda = 1'b1, s_drive = 1'b0, s_rw = 1'b0, s_mack = 1'b1;
    logic [3:0]  s_bits = '0;
    logic [7:0]  s_shift = '0, s_ptr = '0, s_txb, s_txn;
    logic [2:0]  s_idx = '0;
    logic [1:0]  s_sub = '0;
    logic [7:0]  reg0 = '0;
    logic [31:0] reg1 = '0;
    logic        preset_req = 1'b0;
    logic [31:0] preset_val = '0;
    int unsigned start_cnt = 0, rx_n = 0;
    logic [7:0]  rx_log [64];
    logic [3:0]  mack_log = '0;

    assign sda_bus = s_drive ? 1'b0 : 1'bz;

    always_comb begin
        s_txb = (s_ptr == 8'h00) ? reg0 : reg1[{s_sub, 3'b000} +: 8];
        s_txn = (s_ptr == 8'h00) ? reg0 : reg1[{s_sub + 2'd1, 3'b000} +: 8];
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ph       <= S_IDLE;
            s_drive    <= 1'b0;
            s_prev_scl <= 1'b1;
            s_prev_sda <= 1'b1;
        end else begin
            s_prev_scl <= scl;
            s_prev_sda <= sda_bus;
            if (preset_req) reg1 <= preset_val;
            if (s_prev_scl && scl && s_prev_sda && !sda_bus) begin
                s_ph      <= S_RX;
                s_bits    <= '0;
                s_idx     <= '0;
                s_sub     <= '0;
                s_drive   <= 1'b0;
                start_cnt <= start_cnt + 1;
            end else if (s_prev_scl && scl && !s_prev_sda && sda_bus) begin
                s_ph    <= S_IDLE;
                s_drive <= 1'b0;
            end else if (!s_prev_scl && scl) begin
                if (s_ph == S_RX) begin
                    s_shift <= {s_shift[6:0], sda_bus};
                    s_bits  <= s_bits + 4'd1;
                end else if (s_ph == S_TX) begin
                    s_bits <= s_bits + 4'd1;
                end else if (s_ph == S_MACK) begin
                    s_mack   <= sda_bus;
                    mack_log <= {mack_log[2:0], sda_bus};
                end
            end else if (s_prev_scl && !scl) begin
                case (s_ph)
                    S_RX: if (s_bits == 4'd8) begin
                        s_idx  <= s_idx + 3'd1;
                        s_bits <= '0;
                        if (s_idx == 3'd0) begin
                            if (s_shift[7:1] == 7'h01) begin
                                s_rw    <= s_shift[0];
                                s_ph    <= S_ACK;
                                s_drive <= 1'b1;
                            end else begin
                                s_ph <= S_IDLE;
                            end
                        end else begin
                            s_ph    <= S_ACK;
                            s_drive <= 1'b1;
                            if (s_idx == 3'd1) begin
                                s_ptr <= s_shift;
                            end else begin
                                if (s_ptr == 8'h00) reg0 <= s_shift;
                                else reg1[{s_sub, 3'b000} +: 8] <= s_shift;
                                s_sub <= s_sub + 2'd1;
                                if (rx_n < 64) begin
                                    rx_log[rx_n] <= s_shift;
                                    rx_n <= rx_n + 1;
                                end
                            end
                        end
                    end
                    S_ACK: begin
                        s_bits <= '0;
                        if (s_rw) begin
                            s_ph    <= S_TX;
                            s_drive <= ~s_txb[7];
                        end else begin
                            s_ph    <= S_RX;
                            s_drive <= 1'b0;
                        end
                    end
                    S_TX: begin
                        if (s_bits == 4'd8) begin
                            s_drive <= 1'b0;
                            s_ph    <= S_MACK;
                        end else begin
                            s_drive <= ~s_txb[3'd7 - s_bits[2:0]];
                        end
                    end
                    S_MACK: begin
                        if (!s_mack) begin
                            s_sub   <= s_sub + 2'd1;
                            s_bits  <= '0;
                            s_ph    <= S_TX;
                            s_drive <= ~s_txn[7];
                        end else begin
                            s_ph <= S_IDLE;
                        end
                    end
                    default: s_drive <= 1'b0;
                endcase
            end
        end
    end

    int unsigned n_checks = 0, n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int unsigned lat;
    logic        last_err, got_done;
    logic [31:0] last_rd;

    task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [1:0] len, input logic [31:0] wd, input bit glitch);
        int unsigned c0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_dev   = dev;
        cmd_reg   = rg;
        cmd_len   = len;
        cmd_wdata = wd;
        c0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (glitch) begin
            cmd_rw    = ~rw;
            cmd_reg   = 8'h01;
            cmd_len   = 2'd3;
            cmd_wdata = ~wd;
        end
        got_done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (glitch) begin
                cmd_valid = (i >= 40 && i < 60);
                if (i == 50) chk("ready_while_busy", {31'b0, cmd_ready}, 32'd0);
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        lat      = cyc - c0 - 1;
        last_err = ack_err;
        last_rd  = rdata;
        chk("done_seen", {31'b0, got_done}, 32'd1);
    endtask

    int unsigned rb, rxb, sb;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_scl", {31'b0, scl}, 32'd1);
        chk("rst_sda", {31'b0, sda_bus}, 32'd1);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ackerr", {31'b0, ack_err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        // single-byte write to reg 0x00
        rb = rise_n;
        run_cmd(1'b0, 7'h01, 8'h00, 2'd0, 32'h0000_00A5, 1'b0);
        chk("t1_ackerr", {31'b0, last_err}, 32'd0);
        chk("t1_reg0", {24'b0, reg0}, 32'h0000_00A5);
        chk("t1_latency", lat, 116 * CLK_DIV);
        chk("t1_scl_period", rise_cyc[rb + 1] - rise_cyc[rb], 4 * CLK_DIV);
        @(negedge clk);
        chk("t1_done_one_clk", {31'b0, done}, 32'd0);
        chk("t1_idle_scl", {31'b0, scl}, 32'd1);

        // four-byte write to reg 0x01
        rxb = rx_n;
        run_cmd(1'b0, 7'h01, 8'h01, 2'd3, 32'h1234_5678, 1'b0);
        chk("t2_ackerr", {31'b0, last_err}, 32'd0);
        chk("t2_reg1", reg1, 32'h1234_5678);
        chk("t2_byte0", {24'b0, rx_log[rxb]}, 32'h78);
        chk("t2_byte1", {24'b0, rx_log[rxb + 1]}, 32'h56);
        chk("t2_byte2", {24'b0, rx_log[rxb + 2]}, 32'h34);
        chk("t2_byte3", {24'b0, rx_log[rxb + 3]}, 32'h12);
        chk("t2_latency", lat, 224 * CLK_DIV);

        // four-byte read of preset reg 0x01
        @(posedge clk);
        preset_val = 32'hCAFE_F00D;
        preset_req = 1'b1;
        @(posedge clk);
        preset_req = 1'b0;
        sb = start_cnt;
        run_cmd(1'b1, 7'h01, 8'h01, 2'd3, 32'h0, 1'b0);
        chk("t3_rdata", last_rd, 32'hCAFE_F00D);
        chk("t3_ackerr", {31'b0, last_err}, 32'd0);
        chk("t3_starts", start_cnt - sb, 32'd2);
        chk("t3_mack_seq", {28'b0, mack_log}, 32'h1);
        chk("t3_latency", lat, 264 * CLK_DIV);

        // one-byte read: upper bytes stay zero
        run_cmd(1'b1, 7'h01, 8'h00, 2'd0, 32'h0, 1'b0);
        chk("t4_rdata", last_rd, 32'h0000_00A5);
        chk("t4_ackerr", {31'b0, last_err}, 32'd0);

        // absent device: abort after first address byte
        run_cmd(1'b0, 7'h02, 8'h00, 2'd0, 32'h0000_0011, 1'b0);
        chk("t5_ackerr", {31'b0, last_err}, 32'd1);
        chk("t5_rdata_cleared", last_rd, 32'd0);
        chk("t5_latency", lat, 44 * CLK_DIV);
        @(negedge clk);
        chk("t5_scl_idle", {31'b0, scl}, 32'd1);
        chk("t5_sda_idle", {31'b0, sda_bus}, 32'd1);
        chk("t5_ready", {31'b0, cmd_ready}, 32'd1);

        // new command attempts while busy are ignored
        run_cmd(1'b0, 7'h01, 8'h00, 2'd0, 32'h0000_003C, 1'b1);
        chk("t6_ackerr", {31'b0, last_err}, 32'd0);
        chk("t6_reg0", {24'b0, reg0}, 32'h0000_003C);
        chk("t6_reg1_kept", reg1, 32'hCAFE_F00D);
        chk("t6_latency", lat, 116 * CLK_DIV);
        repeat (50) @(negedge clk);
        chk("t6_idle_after", {31'b0, busy}, 32'd0);

        // reset in the middle of WDATA
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_dev   = 7'h01;
        cmd_reg   = 8'h01;
        cmd_len   = 2'd3;
        cmd_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (400) @(negedge clk);
        chk("t7_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_scl", {31'b0, scl}, 32'd1);
        chk("t7_sda", {31'b0, sda_bus}, 32'd1);
        chk("t7_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(1'b0, 7'h01, 8'h00, 2'd0, 32'h0000_005A, 1'b0);
        chk("t7_ackerr", {31'b0, last_err}, 32'd0);
        chk("t7_reg0", {24'b0, reg0}, 32'h0000_005A);
        chk("t7_latency", lat, 116 * CLK_DIV);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iic_master.md
Name: iic_master

Overview:
- Single-master I2C controller. Accepts one register-oriented command at a time and drives SCL/SDA to complete it.
- Write: START, dev+W, reg addr, 1-4 data bytes, STOP.
- Read: START, dev+W, reg addr, repeated START, dev+R, 1-4 data bytes, STOP.
- Used by the core-side peripheral bus to reach on-board IIC register devices, including the team's iic_slave example (dev 0x01, reg 0x00 8-bit, reg 0x01 32-bit).

Parameters:
- CLK_DIV, 250, clk cycles per SCL quarter-period; SCL freq = f_clk/(4*CLK_DIV); legal values >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when idle; command accepted when cmd_valid && cmd_ready
- cmd_rw  in  1  1 = read, 0 = write
- cmd_dev  in  7  7-bit device address
- cmd_reg  in  8  register address byte
- cmd_len  in  2  byte count minus 1 (0 = 1 byte .. 3 = 4 bytes)
- cmd_wdata  in  32  write data; byte k = cmd_wdata[8k+:8], byte 0 sent first
- rdata  out  32  read data; byte k lands in rdata[8k+:8]; bytes not read keep 0
- done  out  1  one-clk pulse when STOP completes (or after abort STOP)
- ack_err  out  1  valid with done; 1 = some slave ACK was missing
- busy  out  1  = !cmd_ready
- scl  out  1  push-pull SCL; idle high
- sda  inout  1  open-drain; driven 0 or z only, never 1

Behaviour:
- Reset (async) values: scl=1, sda=z, cmd_ready=1, done=0, ack_err=0, rdata=0, all counters 0, state IDLE. Reset mid-transfer releases the bus immediately; no STOP is generated.
- Command latch: on accept, latch all cmd_* inputs. Clear rdata and ack_err. Start the quarter counter.
- Quarter tick: a counter 0..CLK_DIV-1 pulses tick on wrap. Every bus step advances only on tick.
- Data bit, 4 quarters:
  - Q0: scl=0; change sda.
  - Q1: scl=0; sda stable.
  - Q2: scl=1.
  - Q3: scl=1; sample sda at end of Q3.
  - sda never changes while scl=1, except for START/STOP.
- START (4 quarters): sda released, scl=1; then sda=0 with scl=1; then scl=0.
- Repeated START: scl=0 with sda released; scl=1; sda=0; scl=0.
- STOP (4 quarters): scl=0 with sda=0; scl=1; then release sda; hold one quarter.
- States: IDLE, START, DEVW, REG, WDATA, RSTART, DEVR, RDATA, SACK, MACK, STOP.
  - IDLE -> START on accept.
  - START -> DEVW. Byte sent is {cmd_dev,0}, MSB first.
  - DEVW -> SACK -> REG.
  - REG -> SACK -> WDATA (write) or RSTART (read).
  - WDATA -> SACK. Repeat until len+1 bytes are sent, then -> STOP.
  - RSTART -> DEVR. Byte sent is {cmd_dev,1}.
  - DEVR -> SACK -> RDATA.
  - RDATA (master releases sda, shifts in 8 bits MSB first) -> MACK.
    - MACK drives 0 (ACK) if more bytes remain.
    - On the last byte MACK releases sda (NACK), then -> STOP.
- SACK: master releases sda for one bit time and samples at Q3. A sampled 1 means NACK: set ack_err=1 and go straight to STOP (abort). Captured rdata is retained.
- Bit counter: 3 bits, 7 down to 0. Byte counter: 2 bits, compared against cmd_len, no wrap.
- done: pulses one clk when STOP's last quarter ends. cmd_ready rises in that same cycle.
- cmd_valid while busy is ignored; inputs changing mid-transfer have no effect.
- Transaction length in quarters, write: 4 + 9*4*(2+len+1) + 4.

Test Plan:
- Write reg 0x00, dev 0x01, len 0, wdata 0xA5 to slave -> slave reg1_out=0xA5; done pulse with ack_err=0; scl period = 4*CLK_DIV clk.
- Write reg 0x01, len 3, wdata 0x12345678 -> slave reg2_out=0x12345678; 4 data bytes on the bus in order 78,56,34,12.
- Slave reg2 preset 0xCAFEF00D; read reg 0x01, len 3 -> rdata=0xCAFEF00D. Bus shows a repeated START, master ACK on bytes 0-2 and NACK on byte 3.
- Command to dev 0x02 -> NACK on first address byte; STOP issued; done with ack_err=1; bus returns to scl=1, sda=z.
- Assert cmd_valid again while busy with differing data -> ignored; the first transaction completes unchanged.
- Drop rst_n mid-WDATA -> scl=1, sda=z, cmd_ready=1 within the same cycle; next command completes normally.
